// File: rtl/glm_common_pkg.sv
// Shared GLM execute-stage types: CCI-P c1 channel subset, BRAM read bundle,
// store-engine FSM encoding and the c1 write-header builder.
package glm_common;

  localparam int unsigned NUM_REGS          = 8;
  localparam int unsigned STORE_STAGE_DEPTH = 8;

  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [15:0]  t_ccip_mdata;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'h0,
    eCL_LEN_2 = 2'h1,
    eCL_LEN_4 = 2'h3
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h1,
    eRSP_WRFENCE = 4'h4
  } t_ccip_c1_rsp;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_cci_c1_ReqMemHdr;

  typedef struct packed {
    t_cci_c1_ReqMemHdr hdr;
    t_ccip_clData      data;
    logic              valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic        re;
    logic [15:0] raddr;
  } bram_read;

  // Response FSM reuses this encoding: STATE_READ stands for WAIT.
  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_READ,
    STATE_DONE
  } t_store_state;

  function automatic logic cci_c1Rx_isWriteRsp(input t_if_ccip_c1_Rx rx);
    return rx.rspValid && (rx.hdr.resp_type == eRSP_WRLINE);
  endfunction

  function automatic t_cci_c1_ReqMemHdr store_wr_hdr(input t_ccip_clAddr addr);
    t_cci_c1_ReqMemHdr hdr;
    hdr          = '0;
    hdr.vc_sel   = eVC_VA;
    hdr.sop      = 1'b1;
    hdr.cl_len   = eCL_LEN_1;
    hdr.req_type = eREQ_WRLINE_I;
    hdr.address  = addr;
    hdr.mdata    = '0;
    return hdr;
  endfunction

endpackage

// File: rtl/store_stage_fifo.sv
// Line staging FIFO between the BRAM read pipe and the c1 write port.
// Show-ahead read data; caller never pushes when full or pops when empty.
module store_stage_fifo #(
  parameter int unsigned WIDTH      = 512,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  empty,
  output logic [LOG2_DEPTH:0]   count
);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/execute_store.sv
// DRAM store engine: streams a BRAM line range to host memory as single-line
// c1 writes and reports request/response completion to the sequencer.
module execute_store
  import glm_common::*;
#(
  parameter int unsigned BRAM_READ_LATENCY = 2,
  parameter int unsigned STAGE_DEPTH       = STORE_STAGE_DEPTH,
  parameter int unsigned LOG2_STAGE_DEPTH  = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           op_start,
  output logic           op_done,
  output logic           op_request_done,
  input  logic [31:0]    regs [NUM_REGS],
  input  t_ccip_clAddr   out_addr,
  output logic           mem_re,
  output logic [15:0]    mem_raddr,
  input  logic [511:0]   mem_rdata,
  input  logic           c1TxAlmFull,
  input  t_if_ccip_c1_Rx cp2af_sRx_c1,
  output t_if_ccip_c1_Tx af2cp_sTx_c1
);

  t_store_state                 rd_state;
  t_store_state                 rsp_state;
  t_ccip_clAddr                 dram_base;
  logic [31:0]                  length;
  logic [15:0]                  bram_base;
  logic [31:0]                  num_read;
  logic [31:0]                  num_written;
  logic [31:0]                  num_acked;
  bram_read                     rd_q;
  logic [BRAM_READ_LATENCY-1:0] rd_vld;
  logic [31:0]                  in_flight;
  logic                         fifo_push;
  logic                         fifo_pop;
  logic                         fifo_empty;
  logic [LOG2_STAGE_DEPTH:0]    fifo_count;
  logic [511:0]                 fifo_rdata;
  logic                         last_wr_q;
  logic                         start_ok;
  logic                         rd_ok;
  logic                         unused_inputs;

  assign unused_inputs = ^{regs[0], regs[1], regs[2], regs[5][31:16], regs[6], regs[7],
                           cp2af_sRx_c1.hdr.mdata};

  assign start_ok  = op_start && (rd_state == STATE_IDLE) && (rsp_state == STATE_IDLE);
  assign mem_re    = rd_q.re;
  assign mem_raddr = rd_q.raddr;
  assign fifo_push = rd_vld[BRAM_READ_LATENCY-1];
  assign fifo_pop  = !fifo_empty && !c1TxAlmFull;

  // Reads not yet reflected in fifo_count: the issuing cycle plus every pipe stage.
  always_comb begin
    in_flight = 32'(rd_q.re);
    for (int unsigned i = 0; i < BRAM_READ_LATENCY; i++) begin
      in_flight = in_flight + 32'(rd_vld[i]);
    end
  end

  assign rd_ok = (rd_state == STATE_READ) && (num_read < length) &&
                 ((32'(fifo_count) + in_flight) < 32'(STAGE_DEPTH));

  // Read FSM: latch the operation and issue BRAM reads under the occupancy limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state  <= STATE_IDLE;
      dram_base <= '0;
      length    <= '0;
      bram_base <= '0;
      num_read  <= '0;
      rd_q      <= '0;
    end else begin
      rd_q.re <= 1'b0;
      case (rd_state)
        STATE_IDLE: begin
          if (start_ok) begin
            dram_base <= out_addr + t_ccip_clAddr'(regs[3]);
            length    <= regs[4];
            bram_base <= regs[5][15:0];
            num_read  <= '0;
            rd_state  <= (regs[4] == '0) ? STATE_DONE : STATE_READ;
          end
        end
        STATE_READ: begin
          if (rd_ok) begin
            rd_q.re    <= 1'b1;
            rd_q.raddr <= bram_base + num_read[15:0];
            num_read   <= num_read + 32'd1;
            if (num_read == length - 32'd1) rd_state <= STATE_DONE;
          end
        end
        STATE_DONE: rd_state <= STATE_IDLE;
        default:    rd_state <= STATE_IDLE;
      endcase
    end
  end

  // Valid tags travelling alongside the BRAM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_vld <= '0;
    else          rd_vld <= (rd_vld << 1) | BRAM_READ_LATENCY'(rd_q.re);
  end

  store_stage_fifo #(
    .WIDTH      (512),
    .DEPTH      (STAGE_DEPTH),
    .LOG2_DEPTH (LOG2_STAGE_DEPTH)
  ) u_stage_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (mem_rdata),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Write issue: registered c1 request and request-completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      af2cp_sTx_c1    <= '0;
      num_written     <= '0;
      last_wr_q       <= 1'b0;
      op_request_done <= 1'b0;
    end else begin
      af2cp_sTx_c1.valid <= 1'b0;
      last_wr_q          <= 1'b0;
      op_request_done    <= last_wr_q;
      if (start_ok) begin
        num_written <= '0;
        if (regs[4] == '0) op_request_done <= 1'b1;
      end else if (fifo_pop) begin
        af2cp_sTx_c1.valid <= 1'b1;
        af2cp_sTx_c1.hdr   <= store_wr_hdr(dram_base + t_ccip_clAddr'(num_written));
        af2cp_sTx_c1.data  <= fifo_rdata;
        num_written        <= num_written + 32'd1;
        last_wr_q          <= (num_written == length - 32'd1);
      end
    end
  end

  // Response FSM: count write acks, pulse op_done from DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_state <= STATE_IDLE;
      num_acked <= '0;
      op_done   <= 1'b0;
    end else begin
      op_done <= 1'b0;
      case (rsp_state)
        STATE_IDLE: begin
          if (start_ok) begin
            num_acked <= '0;
            rsp_state <= (regs[4] == '0) ? STATE_DONE : STATE_READ;
          end
        end
        STATE_READ: begin
          if (cci_c1Rx_isWriteRsp(cp2af_sRx_c1)) begin
            num_acked <= num_acked + 32'd1;
            if (num_acked == length - 32'd1) rsp_state <= STATE_DONE;
          end
        end
        STATE_DONE: begin
          op_done   <= 1'b1;
          rsp_state <= STATE_IDLE;
        end
        default: rsp_state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_store.sv
// Scoreboard bench for execute_store: directed operations push expected
// writes and BRAM read addresses; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_execute_store;
  import glm_common::*;

  localparam int unsigned LAT = 2;

  typedef struct {
    t_ccip_clAddr addr;
    logic [511:0] data;
  } exp_wr_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           op_start;
  logic           op_done;
  logic           op_request_done;
  logic [31:0]    regs [NUM_REGS];
  t_ccip_clAddr   out_addr;
  logic           mem_re;
  logic [15:0]    mem_raddr;
  logic [511:0]   mem_rdata;
  logic           c1TxAlmFull;
  t_if_ccip_c1_Rx rx;
  t_if_ccip_c1_Tx tx;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0, reqdone_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  int unsigned done_cyc = 0, reqdone_cyc = 0, last_wr_cyc = 0, last_rsp_cyc = 0, start_cyc = 0;

  exp_wr_t     wr_q[$];
  logic [15:0] exp_rd_q[$];

  execute_store #(
    .BRAM_READ_LATENCY (LAT),
    .STAGE_DEPTH       (8),
    .LOG2_STAGE_DEPTH  (3)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .op_start        (op_start),
    .op_done         (op_done),
    .op_request_done (op_request_done),
    .regs            (regs),
    .out_addr        (out_addr),
    .mem_re          (mem_re),
    .mem_raddr       (mem_raddr),
    .mem_rdata       (mem_rdata),
    .c1TxAlmFull     (c1TxAlmFull),
    .cp2af_sRx_c1    (rx),
    .af2cp_sTx_c1    (tx)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [511:0] line_of(input logic [15:0] a);
    logic [31:0] w;
    w = {a ^ 16'h5A5A, a};
    return {16{w}};
  endfunction

  function automatic t_cci_c1_ReqMemHdr exp_hdr(input t_ccip_clAddr a);
    t_cci_c1_ReqMemHdr h;
    h          = '0;
    h.req_type = eREQ_WRLINE_I;
    h.vc_sel   = eVC_VA;
    h.cl_len   = eCL_LEN_1;
    h.sop      = 1'b1;
    h.mdata    = 16'h0;
    h.address  = a;
    return h;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // BRAM model (LAT-cycle read) and c1 response echo, driven at negedge.
  logic [16:0] bram_pipe [LAT+1];
  logic [4:0]  rsp_sr;
  initial begin
    for (int i = 0; i <= LAT; i++) bram_pipe[i] = '0;
    rsp_sr    = '0;
    rx        = '0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      for (int i = LAT; i > 0; i--) bram_pipe[i] = bram_pipe[i-1];
      bram_pipe[0] = {mem_re, mem_raddr};
      mem_rdata = bram_pipe[LAT][16] ? line_of(bram_pipe[LAT][15:0]) : {16{32'hDEADBEEF}};
      rsp_sr = {rsp_sr[3:0], tx.valid};
      rx.hdr.resp_type = eRSP_WRLINE;
      rx.hdr.mdata     = 16'h0;
      rx.rspValid      = rsp_sr[4];
      if (rsp_sr[4]) last_rsp_cyc = cyc;
    end
  end

  // Monitor: pops scoreboard entries whenever the DUT presents a read or write.
  initial begin
    exp_wr_t e;
    logic    prev_afull;
    prev_afull = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mem_re) begin
          rd_cnt++;
          if (exp_rd_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_mem_re: got raddr %0h required no read", mem_raddr);
          end else begin
            check("mem_raddr", 128'(mem_raddr), 128'(exp_rd_q.pop_front()));
          end
        end
        if (tx.valid) begin
          wr_cnt++;
          last_wr_cyc = cyc;
          check("valid_while_almfull", 128'(prev_afull), 128'd0);
          if (wr_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_write: got addr %0h required no write", tx.hdr.address);
          end else begin
            e = wr_q.pop_front();
            check("wr_hdr", 128'(tx.hdr), 128'(exp_hdr(e.addr)));
            n_checks++;
            if (tx.data !== e.data) begin
              n_fail++;
              $display("FAIL wr_data: got %h required %h", tx.data, e.data);
            end
          end
        end
        if (op_request_done) begin reqdone_cnt++; reqdone_cyc = cyc; end
        if (op_done)         begin done_cnt++;    done_cyc    = cyc; end
      end
      prev_afull = c1TxAlmFull;
    end
  end

  task automatic start_op(input int unsigned len, input logic [31:0] off,
                          input t_ccip_clAddr base, input logic [15:0] boff);
    t_ccip_clAddr a;
    exp_wr_t      e;
    regs[3]  = off;
    regs[4]  = len;
    regs[5]  = {16'hABCD, boff};
    out_addr = base;
    a = base + t_ccip_clAddr'(off);
    for (int unsigned i = 0; i < len; i++) begin
      e.addr = a + t_ccip_clAddr'(i);
      e.data = line_of(boff + 16'(i));
      wr_q.push_back(e);
      exp_rd_q.push_back(boff + 16'(i));
    end
    @(posedge clk); #1;
    op_start  = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    op_start  = 1'b0;
  endtask

  task automatic wait_done(input int unsigned target, input int unsigned budget, input string name);
    int unsigned n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (done_cnt < target) begin
      n_fail++;
      $display("FAIL %s_timeout: got op_done count %0d required %0d", name, done_cnt, target);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned d0, r0, w0, rd0, n;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
    out_addr    = '0;
    c1TxAlmFull = 1'b0;
    op_start    = 1'b0;
    reset_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",   128'(tx.valid),        128'd0);
    check("rst_mem_re",  128'(mem_re),          128'd0);
    check("rst_done",    128'(op_done),         128'd0);
    check("rst_reqdone", 128'(op_request_done), 128'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic length-4 transfer
    d0 = done_cnt; r0 = reqdone_cnt; w0 = wr_cnt;
    start_op(4, 32'h10, 42'h1000, 16'h0020);
    wait_done(d0 + 1, 200, "t1");
    repeat (8) @(posedge clk);
    check("t1_writes",      128'(wr_cnt - w0),       128'd4);
    check("t1_reqdone_cnt", 128'(reqdone_cnt - r0),  128'd1);
    check("t1_done_cnt",    128'(done_cnt - d0),     128'd1);
    check("t1_reqdone_cyc", 128'(reqdone_cyc),       128'(last_wr_cyc + 1));
    check("t1_done_cyc",    128'(done_cyc),          128'(last_rsp_cyc + 2));
    check("t1_queue_empty", 128'(wr_q.size()),       128'd0);

    // Zero length
    d0 = done_cnt; r0 = reqdone_cnt; w0 = wr_cnt; rd0 = rd_cnt;
    start_op(0, 32'h5, 42'h3000, 16'h0007);
    repeat (5) @(posedge clk);
    check("t2_reqdone_cnt", 128'(reqdone_cnt - r0), 128'd1);
    check("t2_done_cnt",    128'(done_cnt - d0),    128'd1);
    check("t2_reqdone_cyc", 128'(reqdone_cyc),      128'(start_cyc + 1));
    check("t2_done_cyc",    128'(done_cyc),         128'(start_cyc + 2));
    check("t2_writes",      128'(wr_cnt - w0),      128'd0);
    check("t2_reads",       128'(rd_cnt - rd0),     128'd0);

    // Length 32, back-pressure mid-transfer, DRAM address wrap at 2^42
    d0 = done_cnt; w0 = wr_cnt; rd0 = rd_cnt;
    start_op(32, 32'h8, 42'h3FF_FFFF_FFF0, 16'h0100);
    repeat (6) @(posedge clk);
    #1 c1TxAlmFull = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("t3_stall_depth", 128'((rd_cnt - rd0) - (wr_cnt - w0)), 128'd8);
    check("t3_mem_re_stalled", 128'(mem_re), 128'd0);
    c1TxAlmFull = 1'b0;
    wait_done(d0 + 1, 600, "t3");
    repeat (8) @(posedge clk);
    check("t3_writes",      128'(wr_cnt - w0),    128'd32);
    check("t3_done_cnt",    128'(done_cnt - d0),  128'd1);
    check("t3_queue_empty", 128'(wr_q.size()),    128'd0);

    // BRAM address wrap: FFFE, FFFF, 0000, 0001
    d0 = done_cnt; w0 = wr_cnt; rd0 = rd_cnt;
    start_op(4, 32'h0, 42'h2000, 16'hFFFE);
    wait_done(d0 + 1, 200, "t4");
    repeat (8) @(posedge clk);
    check("t4_reads",        128'(rd_cnt - rd0),      128'd4);
    check("t4_writes",       128'(wr_cnt - w0),       128'd4);
    check("t4_rdq_empty",    128'(exp_rd_q.size()),   128'd0);

    // Reset after 3 of 10 writes, then a fresh length-2 operation
    w0 = wr_cnt;
    start_op(10, 32'h0, 42'h5000, 16'h0040);
    n = 0;
    while ((wr_cnt - w0) < 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("t5_reached_3_writes", 128'((wr_cnt - w0) >= 3), 128'd1);
    #1 reset_n = 1'b0;
    #1;
    check("t5_rst_valid",   128'(tx.valid),        128'd0);
    check("t5_rst_mem_re",  128'(mem_re),          128'd0);
    check("t5_rst_done",    128'(op_done),         128'd0);
    check("t5_rst_reqdone", 128'(op_request_done), 128'd0);
    wr_q.delete();
    exp_rd_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    d0 = done_cnt; r0 = reqdone_cnt;
    repeat (12) @(posedge clk);
    check("t5_idle_done",    128'(done_cnt - d0),    128'd0);
    check("t5_idle_reqdone", 128'(reqdone_cnt - r0), 128'd0);
    w0 = wr_cnt;
    start_op(2, 32'h0, 42'h6000, 16'h0080);
    wait_done(d0 + 1, 200, "t5");
    repeat (8) @(posedge clk);
    check("t5_writes",      128'(wr_cnt - w0),      128'd2);
    check("t5_done_cnt",    128'(done_cnt - d0),    128'd1);
    check("t5_reqdone_cnt", 128'(reqdone_cnt - r0), 128'd1);

    // op_start while busy is ignored
    d0 = done_cnt; r0 = reqdone_cnt; w0 = wr_cnt;
    start_op(8, 32'h20, 42'h7000, 16'h0200);
    repeat (3) @(posedge clk);
    #1;
    regs[3]  = 32'h99;
    regs[4]  = 32'd3;
    regs[5]  = 32'h0555;
    op_start = 1'b1;
    @(posedge clk);
    #1 op_start = 1'b0;
    wait_done(d0 + 1, 200, "t6");
    repeat (20) @(posedge clk);
    check("t6_writes",      128'(wr_cnt - w0),      128'd8);
    check("t6_done_cnt",    128'(done_cnt - d0),    128'd1);
    check("t6_reqdone_cnt", 128'(reqdone_cnt - r0), 128'd1);
    check("t6_queue_empty", 128'(wr_q.size()),      128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
